// File: rtl/keypad_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scan_ctrl
// Brief    : 4x4 active-low keypad scanner with press/release debounce.
//            Optional auto-repeat while held: define KEYPAD_REPEAT_EN.
// Revision : 1.0
// ============================================================================
module keypad_scan_ctrl #(
    parameter int SETTLE_CYCLES   = 16,
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int REPEAT_CYCLES   = 25_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_validn,
    output logic       scan_busy
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES);
    localparam logic [DW-1:0] DEB_LAST    = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_SCAN     = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_HELD     = 2'd2,
        S_RELEASE  = 2'd3
    } state_t;

    state_t         r_state;
    logic [3:0]     r_sync;
    logic [3:0]     r_rs;
    logic [1:0]     r_col_idx;
    logic [1:0]     r_row_idx;
    logic [SW-1:0]  r_settle_cnt;
    logic [DW-1:0]  r_deb_cnt;

`ifdef KEYPAD_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
    logic [RW-1:0]  r_rep_cnt;
`else
    logic           unused_repeat;
    assign unused_repeat = (REPEAT_CYCLES != 0);
`endif

    logic [3:0] w_low;
    logic       w_single;
    logic [1:0] w_row_enc;
    logic       w_row_match;
    logic       w_row_high;
    logic [1:0] w_next_col;

    assign w_low       = ~r_rs;
    assign w_single    = (w_low != 4'b0000) && ((w_low & (w_low - 4'd1)) == 4'b0000);
    assign w_row_match = (r_rs == ~(4'b0001 << r_row_idx));
    assign w_row_high  = r_rs[r_row_idx];
    assign w_next_col  = r_col_idx + 2'd1;

    always_comb begin
        w_row_enc = 2'd0;
        if (w_low[1]) w_row_enc = 2'd1;
        if (w_low[2]) w_row_enc = 2'd2;
        if (w_low[3]) w_row_enc = 2'd3;
    end

    // Index is {row, col}; '*' maps to F and '#' to E.
    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'd0:  code = 4'h1;
            4'd1:  code = 4'h2;
            4'd2:  code = 4'h3;
            4'd3:  code = 4'hA;
            4'd4:  code = 4'h4;
            4'd5:  code = 4'h5;
            4'd6:  code = 4'h6;
            4'd7:  code = 4'hB;
            4'd8:  code = 4'h7;
            4'd9:  code = 4'h8;
            4'd10: code = 4'h9;
            4'd11: code = 4'hC;
            4'd12: code = 4'hF;
            4'd13: code = 4'h0;
            4'd14: code = 4'hE;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_SCAN;
            r_sync       <= 4'hF;
            r_rs         <= 4'hF;
            r_col_idx    <= 2'd0;
            r_row_idx    <= 2'd0;
            r_settle_cnt <= '0;
            r_deb_cnt    <= '0;
            col_n        <= 4'b1110;
            key_code     <= 4'h0;
            key_validn   <= 1'b1;
            scan_busy    <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            r_rep_cnt    <= '0;
`endif
        end else begin
            r_sync <= row_n;
            r_rs   <= r_sync;
            case (r_state)
                S_SCAN: begin
                    if (r_settle_cnt != SETTLE_LAST) begin
                        r_settle_cnt <= r_settle_cnt + SW'(1);
                    end else if (w_single) begin
                        r_row_idx <= w_row_enc;
                        r_deb_cnt <= '0;
                        scan_busy <= 1'b1;
                        r_state   <= S_DEBOUNCE;
                    end else begin
                        // Idle column or ghosting pattern: move on.
                        r_col_idx    <= w_next_col;
                        col_n        <= ~(4'b0001 << w_next_col);
                        r_settle_cnt <= '0;
                    end
                end
                S_DEBOUNCE: begin
                    if (!w_row_match) begin
                        r_settle_cnt <= '0;
                        scan_busy    <= 1'b0;
                        r_state      <= S_SCAN;
                    end else if (r_deb_cnt == DEB_LAST) begin
                        key_code   <= key_map(r_row_idx, r_col_idx);
                        key_validn <= 1'b0;
                        r_state    <= S_HELD;
`ifdef KEYPAD_REPEAT_EN
                        r_rep_cnt  <= '0;
`endif
                    end else begin
                        r_deb_cnt <= r_deb_cnt + DW'(1);
                    end
                end
                S_HELD: begin
                    if (w_row_high) begin
                        r_deb_cnt <= '0;
                        r_state   <= S_RELEASE;
`ifdef KEYPAD_REPEAT_EN
                        key_validn <= 1'b0;
`endif
                    end else begin
`ifdef KEYPAD_REPEAT_EN
                        // One-cycle high pulse per repeat period looks like a fresh press.
                        if (r_rep_cnt == REP_LAST) begin
                            key_validn <= 1'b1;
                            r_rep_cnt  <= '0;
                        end else begin
                            key_validn <= 1'b0;
                            r_rep_cnt  <= r_rep_cnt + RW'(1);
                        end
`endif
                    end
                end
                S_RELEASE: begin
                    if (!w_row_high) begin
                        r_state <= S_HELD;
                    end else if (r_deb_cnt == DEB_LAST) begin
                        key_validn   <= 1'b1;
                        r_col_idx    <= w_next_col;
                        col_n        <= ~(4'b0001 << w_next_col);
                        r_settle_cnt <= '0;
                        scan_busy    <= 1'b0;
                        r_state      <= S_SCAN;
                    end else begin
                        r_deb_cnt <= r_deb_cnt + DW'(1);
                    end
                end
                default: r_state <= S_SCAN;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_scan_ctrl
// Brief    : Self-checking bench for keypad_scan_ctrl with a keypad matrix model.
// Revision : 1.0
// ============================================================================
module tb_keypad_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [3:0]  key_code;
    logic        key_validn;
    logic        scan_busy;
    logic [15:0] pressed = '0;   // bit row*4+col

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    bit prev_v;
    int n_fall, n_rise;

    keypad_scan_ctrl #(
        .SETTLE_CYCLES  (2),
        .DEBOUNCE_CYCLES(8),
        .REPEAT_CYCLES  (40)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row_n     (row_n),
        .col_n     (col_n),
        .key_code  (key_code),
        .key_validn(key_validn),
        .scan_busy (scan_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
    end

    typedef struct {
        string      name;
        int         row;
        int         col;
        logic [3:0] exp_code;
        logic [3:0] exp_col;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_mon();
        tick();
        if (prev_v && !key_validn) n_fall++;
        if (!prev_v && key_validn) n_rise++;
        prev_v = key_validn;
    endtask

    task automatic mon_start();
        prev_v = key_validn;
        n_fall = 0;
        n_rise = 0;
    endtask

    function automatic logic [3:0] col_pat(input int c);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << c);
    endfunction

    task automatic wait_col_entry(input logic [3:0] pat, output bit ok);
        logic [3:0] prev;
        ok = 1'b0;
        prev = col_n;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (col_n == pat && prev != pat) begin
                ok = 1'b1;
                break;
            end
            prev = col_n;
        end
    endtask

    task automatic wait_validn(input logic val, input int budget, output int t);
        t = -1000;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (key_validn == val) begin
                t = cyc;
                break;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bit ok;
        int t_row, t_acc, t_rel, t_up, t_r, t_last, n_high, bidx;
        bit stable;

        vecs[0] = '{"key6", 1, 2, 4'h6, 4'b1011};
        vecs[1] = '{"key1", 0, 0, 4'h1, 4'b1110};
        vecs[2] = '{"keyA", 0, 3, 4'hA, 4'b0111};
        vecs[3] = '{"keystar", 3, 0, 4'hF, 4'b1110};
        vecs[4] = '{"key0", 3, 1, 4'h0, 4'b1101};
        vecs[5] = '{"keyD", 3, 3, 4'hD, 4'b0111};
        vecs[6] = '{"key9", 2, 2, 4'h9, 4'b1011};

        // Reset values, then free-running scan.
        tick();
        tick();
        check("rst col_n", col_n, 4'b1110);
        check("rst key_code", key_code, 4'h0);
        check("rst key_validn", key_validn, 1);
        check("rst scan_busy", scan_busy, 0);
        rst_n = 1'b1;
        for (int k = 0; k < 15; k++) begin
            if (k > 0) tick();
            check($sformatf("scan col_n k=%0d", k), col_n, col_pat((k / 3) % 4));
        end
        check("scan key_validn", key_validn, 1);

        // Table of single clean presses.
        for (int i = 0; i < 7; i++) begin
            bidx = vecs[i].row * 4 + vecs[i].col;
            wait_col_entry(col_pat((vecs[i].col + 3) % 4), ok);
            check({vecs[i].name, " scan reach"}, ok, 1);
            pressed[bidx] = 1'b1;
            t_row = -1000;
            t_acc = -1;
            for (int j = 0; j < 60; j++) begin
                tick();
                if (t_row < 0 && row_n != 4'hF) t_row = cyc;
                if (!key_validn) begin
                    t_acc = cyc;
                    break;
                end
            end
            check({vecs[i].name, " press latency"}, t_acc - t_row, 11);
            check({vecs[i].name, " key_code"}, key_code, vecs[i].exp_code);
            check({vecs[i].name, " col_n frozen"}, col_n, vecs[i].exp_col);
            check({vecs[i].name, " scan_busy"}, scan_busy, 1);
            stable = 1'b1;
            for (int j = 0; j < 30; j++) begin
                tick();
                if (col_n != vecs[i].exp_col || key_validn || key_code != vecs[i].exp_code)
                    stable = 1'b0;
            end
            check({vecs[i].name, " hold stable"}, stable, 1);
            pressed[bidx] = 1'b0;
            t_rel = cyc;
            wait_validn(1'b1, 40, t_up);
            check({vecs[i].name, " release latency"}, t_up - t_rel, 11);
            check({vecs[i].name, " code retained"}, key_code, vecs[i].exp_code);
            check({vecs[i].name, " col advance"}, col_n, col_pat((vecs[i].col + 1) % 4));
            check({vecs[i].name, " busy clear"}, scan_busy, 0);
        end

        // '#' with bounce on press and release.
        wait_col_entry(col_pat(2), ok);
        mon_start();
        for (int b = 0; b < 4; b++) begin
            pressed[14] = (b % 2 == 0);
            for (int j = 0; j < 3; j++) tick_mon();
        end
        check("bounce no early accept", n_fall, 0);
        pressed[14] = 1'b1;
        for (int j = 0; j < 30; j++) tick_mon();
        check("bounce one low period", n_fall, 1);
        check("bounce key_code", key_code, 4'hE);
        for (int b = 0; b < 4; b++) begin
            pressed[14] = (b % 2 == 1);
            for (int j = 0; j < 3; j++) tick_mon();
        end
        check("release bounce no early rise", n_rise, 0);
        pressed[14] = 1'b0;
        t_last = cyc;
        t_up = -1000;
        for (int j = 0; j < 40; j++) begin
            tick_mon();
            if (key_validn) begin
                t_up = cyc;
                break;
            end
        end
        check("release bounce latency", t_up - t_last, 11);
        check("release bounce single rise", n_rise, 1);
        check("release bounce code", key_code, 4'hE);

        // Ghosting: rows 0 and 2 low on column 0.
        wait_col_entry(col_pat(3), ok);
        pressed[0] = 1'b1;
        pressed[8] = 1'b1;
        mon_start();
        wait_col_entry(col_pat(0), ok);
        check("ghost reach col0", ok, 1);
        for (int j = 0; j < 3; j++) begin
            tick_mon();
            if (scan_busy) ok = 1'b0;
        end
        check("ghost col advance", col_n, 4'b1101);
        check("ghost never busy", ok, 1);
        check("ghost no accept", n_fall, 0);
        pressed = '0;

        // Asynchronous reset while '5' is held.
        wait_col_entry(col_pat(0), ok);
        pressed[5] = 1'b1;
        wait_validn(1'b0, 40, t_acc);
        check("key5 code", key_code, 4'h5);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst col_n", col_n, 4'b1110);
        check("midrst key_code", key_code, 4'h0);
        check("midrst key_validn", key_validn, 1);
        check("midrst scan_busy", scan_busy, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        t_r = cyc;
        wait_validn(1'b0, 30, t_acc);
        check("postrst relatch latency", t_acc - t_r, 14);
        check("postrst key_code", key_code, 4'h5);
        pressed[5] = 1'b0;
        wait_validn(1'b1, 40, t_up);
        check("postrst released", key_validn, 1);

        // Long hold of '1'.
        wait_col_entry(col_pat(3), ok);
        pressed[0] = 1'b1;
        wait_validn(1'b0, 40, t_acc);
        n_high = 0;
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (key_validn) n_high++;
`ifdef KEYPAD_REPEAT_EN
            if (k == 39) check("repeat +39 low", key_validn, 0);
            if (k == 40) check("repeat +40 high", key_validn, 1);
            if (k == 41) check("repeat +41 low", key_validn, 0);
            if (k == 80) check("repeat +80 high", key_validn, 1);
`endif
        end
`ifdef KEYPAD_REPEAT_EN
        check("repeat pulse count", n_high, 2);
`else
        check("no repeat pulses", n_high, 0);
`endif
        check("long hold key_code", key_code, 4'h1);
        pressed[0] = 1'b0;
        wait_validn(1'b1, 40, t_up);
        check("long hold released", key_validn, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
